// File: rtl/freq_display_driver.sv
`default_nettype none
// ============================================================================
//  Module   : freq_display_driver
//  Purpose  : Converts a 12-bit binary frequency value to 4-digit BCD using a
//             sequential double-dabble converter, then drives a multiplexed
//             4-digit common-anode 7-segment display with leading-zero
//             blanking.
//  Ports    : clk        - system clock, rising-edge active
//             rst_n      - asynchronous active-low reset
//             bnum[11:0] - unsigned binary value to display
//             bcd[15:0]  - last converted value, 4 BCD digits ([3:0] = units)
//             bcd_valid  - one-cycle pulse when bcd updates
//             busy       - high while a conversion is in progress
//             an[3:0]    - active-low digit enables, an[0] = units
//             seg[6:0]   - active-low segments {g,f,e,d,c,b,a}
//             dp         - active-low decimal point, held off
//  Revision : 1.0 - initial release
// ============================================================================
module freq_display_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bnum,
    output logic [15:0] bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_SHIFT = 2'd1;
    localparam logic [1:0]  S_DONE  = 2'd2;

    // The counter holds the index of the shift being performed this cycle,
    // so the twelfth shift happens while it reads 11.
    localparam logic [3:0]  c_last_shift = 4'd11;
    localparam logic [15:0] c_div_max    = 16'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [11:0] r_sr;       // binary bits still to be shifted in
    logic [15:0] r_acc;      // BCD accumulator, never visible on the display
    logic [3:0]  r_cnt;
    logic [11:0] r_cap;      // value being converted
    logic [11:0] r_last;     // value currently shown on bcd
    logic        r_force;    // forces one conversion after reset

    logic        w_change;
    logic        w_start;
    logic        w_shift;
    logic        w_done;
    logic [15:0] w_adj;
    logic [27:0] w_shifted;

    // Compare against the live input only in IDLE; changes during a
    // conversion are picked up on the first IDLE cycle that follows.
    assign w_change = (bnum != r_last) || r_force;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_change) begin
                    w_next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_last_shift) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (datapath strobes)
    // ------------------------------------------------------------------
    always_comb begin
        w_start = 1'b0;
        w_shift = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE:  w_start = w_change;
            S_SHIFT: w_shift = 1'b1;
            S_DONE:  w_done  = 1'b1;
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Double-dabble step: correct each nibble >= 5 before the shift so it
    // carries correctly into the next decade after doubling.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 4; i++) begin : g_adj
        assign w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ?
                                 (r_acc[4*i +: 4] + 4'd3) : r_acc[4*i +: 4];
    end

    // The accumulator MSB is discarded: for a 12-bit input the result tops
    // out at 0x4095, so bit 15 of the adjusted value is always zero.
    assign w_shifted = {w_adj[14:0], r_sr, 1'b0};

    // ------------------------------------------------------------------
    // Converter datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr      <= 12'd0;
            r_acc     <= 16'd0;
            r_cnt     <= 4'd0;
            r_cap     <= 12'd0;
            r_last    <= 12'd0;
            r_force   <= 1'b1;
            bcd       <= 16'd0;
            busy      <= 1'b0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= w_done;
            if (w_start) begin
                r_sr  <= bnum;
                r_cap <= bnum;
                r_acc <= 16'd0;
                r_cnt <= 4'd0;
                busy  <= 1'b1;
            end else if (w_shift) begin
                r_acc <= w_shifted[27:12];
                r_sr  <= w_shifted[11:0];
                r_cnt <= r_cnt + 4'd1;
            end else if (w_done) begin
                bcd     <= r_acc;
                r_last  <= r_cap;
                r_force <= 1'b0;
                busy    <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [15:0] r_presc;
    logic [1:0]  r_digit;
    logic        w_wrap;
    logic [1:0]  w_digit_next;
    logic [1:0]  w_msd;
    logic [3:0]  w_nibble;
    logic [6:0]  w_seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;     // non-decimal nibble: blank
        endcase
        return s;
    endfunction

    assign w_wrap       = (r_presc == c_div_max);
    assign w_digit_next = w_wrap ? (r_digit + 2'd1) : r_digit;

    // Most-significant nonzero digit; zero selects the units digit so the
    // units position is never blanked.
    always_comb begin
        w_msd = 2'd0;
        if (bcd[15:12] != 4'd0) begin
            w_msd = 2'd3;
        end else if (bcd[11:8] != 4'd0) begin
            w_msd = 2'd2;
        end else if (bcd[7:4] != 4'd0) begin
            w_msd = 2'd1;
        end
    end

    // an and seg are loaded from the digit index they will display, so the
    // enable and the pattern always change on the same edge. The display
    // reads only the committed bcd register; a bcd update becomes visible
    // on the following seg load.
    assign w_nibble   = bcd[{w_digit_next, 2'b00} +: 4];
    assign w_seg_next = (w_digit_next > w_msd) ? 7'h7F : seg_decode(w_nibble);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= 16'd0;
            r_digit <= 2'd0;
            an      <= 4'b1110;
            seg     <= 7'b1000000;
        end else begin
            r_presc <= w_wrap ? 16'd0 : (r_presc + 16'd1);
            r_digit <= w_digit_next;
            an      <= ~(4'b0001 << w_digit_next);
            seg     <= w_seg_next;
        end
    end

    assign dp = 1'b1;

endmodule
`default_nettype wire

// File: doc/freq_display_driver.md
FREQ_DISPLAY_DRIVER -- requirements
Module: freq_display_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000, CLK cycles per digit scan slot (legal range 2..65535).
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 bnum  input  12  unsigned binary frequency value from the output stage.
REQ-005 bcd  output  16  registered 4-digit BCD of the last converted bnum; [15:12] is thousands, [3:0] is units.
REQ-006 bcd_valid  output  1  single-cycle pulse when bcd updates.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 an  output  4  digit enables, active-low, one-hot-cold; an[0] drives units.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 dp  output  1  decimal point, active-low; always 1 (off).

Function
REQ-011 Converter FSM states: IDLE, SHIFT, DONE.
REQ-012 IDLE: if bnum != last_val or force_flag is set, the block shall capture bnum into the shift register, clear the BCD accumulator and the shift counter, set busy, and go to SHIFT; otherwise it stays in IDLE.
REQ-013 SHIFT: each cycle, the block shall add 3 to every BCD nibble >= 5, then shift {accumulator, shift register} left by 1 (double-dabble).
REQ-014 SHIFT: after exactly 12 shift cycles, the FSM shall go to DONE.
REQ-015 DONE: the block shall load bcd from the accumulator, set last_val to the captured value, clear force_flag and busy, pulse bcd_valid for 1 cycle, and return to IDLE.
REQ-016 Latency: with bnum captured at edge N, bcd and bcd_valid shall update at edge N+13; the minimum repeat interval is 14 cycles.
REQ-017 bnum changes during SHIFT or DONE shall be ignored; the latest bnum shall be compared on the first IDLE cycle afterwards, so no final value is lost.
REQ-018 A bnum equal to last_val shall start no conversion and produce no bcd_valid pulse.
REQ-019 Range: bnum 0..4095 shall map to bcd 0x0000..0x4095; the accumulator is 16 bits, with no overflow possible.
REQ-020 Scan: a prescaler shall count 0..SCAN_DIV-1 and wrap; on wrap, the digit index (2 bits) shall increment modulo 4 (3 -> 0).
REQ-021 an shall be registered and equal ~(1 << digit index).
REQ-022 seg shall be registered from the selected bcd nibble using the standard active-low 0-9 patterns (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000).
REQ-023 Nibble values 10-15 cannot occur; the block shall blank seg (7'h7F) if one does.
REQ-024 Leading-zero blanking: a digit whose position is above the most-significant nonzero digit shall show 7'h7F.
REQ-025 Digit 0 shall never be blanked.
REQ-026 The display shall read from bcd only, never from the in-progress accumulator, so there is no flicker mid-conversion.
REQ-027 A bcd update and a scan slot change in the same cycle: the new bcd shall take effect on the next seg register update; no glitch value shall be allowed.

Reset
REQ-028 On RST_N low, the block shall set: FSM to IDLE; bcd = 0x0000; last_val = 0; force_flag = 1; busy = 0; bcd_valid = 0.
REQ-029 On RST_N low, the block shall also set: prescaler = 0; digit index = 0; an = 4'b1110; seg = 7'b1000000; dp = 1.
REQ-030 Reset asserted mid-conversion shall abort the conversion immediately, with no bcd_valid pulse.
REQ-031 After RST_N deasserts, force_flag shall make the first IDLE cycle convert the current bnum, even if bnum is 0.

Verification
REQ-032 Scenario: reset with bnum=0 -> an=1110, seg=1000000, dp=1; after release, one bcd_valid pulse 13 cycles after the first IDLE edge, with bcd=0x0000.
REQ-033 Scenario: bnum=1234 -> bcd=0x1234 at capture+13, busy high for exactly those cycles; bnum=4095 -> bcd=0x4095.
REQ-034 Scenario: bnum changes 100 -> 200 at capture+5 -> first result bcd=0x0100; second conversion starts the following IDLE cycle; final bcd=0x0200; exactly 2 bcd_valid pulses.
REQ-035 Scenario: SCAN_DIV=4, bcd=0x0007 -> an sequence 1110, 1101, 1011, 0111, each held 4 cycles, wrapping; seg=1111000 on digit 0 and 7'h7F on digits 1-3.
REQ-036 Scenario: bnum=1005 -> no digit blanked; tens digit shows 1000000.
REQ-037 Scenario: RST_N pulsed low at capture+6 -> outputs return to reset values asynchronously; no bcd_valid pulse; after release, forced reconversion of bnum.
